fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller in front of fetch_receive. Generates sequential PC read
//  requests to instruction memory, tracks in-flight reads and buffers returned words.
//  Presents one instruction per cycle to decode and honours decode stalls. On branch
//  redirect, discards stale responses and restarts at the new PC.
// PARAMETERS
//  DATA_WIDTH       32            instruction width
//  ADDRESS_BITS     32            PC / memory address width
//  RESET_PC         0             PC loaded by reset
//  NOP              32'h00000013  word driven when no valid instruction (addi x0,x0,0)
//  MAX_OUTSTANDING  2             max issued-but-unconsumed words; also FIFO depth (>=1)
// PORTS
//  clock              in   1             single clock, rising edge
//  reset              in   1             synchronous, active-high
//  start              in   1             leave IDLE, begin fetching at program_address
//  program_address    in   ADDRESS_BITS  first PC after start
//  redirect           in   1             branch/jump taken; discard in-flight fetches
//  redirect_pc        in   ADDRESS_BITS  new PC when redirect=1
//  stall              in   1             decode cannot accept this cycle
//  i_mem_read         out  1             read request valid
//  i_mem_read_address out  ADDRESS_BITS  read address (current PC)
//  i_mem_ready        in   1             request accepted when i_mem_read & i_mem_ready
//  i_mem_valid        in   1             one response word, in request order
//  i_mem_data         in   DATA_WIDTH    response data
//  instruction        out  DATA_WIDTH    FIFO head if inst_valid, else NOP
//  inst_PC            out  ADDRESS_BITS  PC of instruction; 0 when !inst_valid
//  inst_valid         out  1             instruction is real, not bubble
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, outstanding=0, FIFO empty; i_mem_read=0,
//   inst_valid=0, instruction=NOP, inst_PC=0. Reset has priority over all inputs, any state.
//  States: IDLE, RUN, DRAIN.
//   IDLE:  no requests. start=1 -> pc<=program_address, resp_pc<=program_address, RUN.
//          redirect ignored.
//   RUN:   i_mem_read=1 iff !redirect and outstanding+fifo_count < MAX_OUTSTANDING.
//          Accept (read&ready) -> pc+=4, outstanding+1.
//   DRAIN: i_mem_read=0. i_mem_valid decrements outstanding; data dropped.
//          When outstanding reaches 0 -> RUN next cycle.
//  redirect=1 in RUN or DRAIN, same cycle:
//   - FIFO cleared, inst_valid=0, instruction=NOP, no request.
//   - pc<=redirect_pc, resp_pc<=redirect_pc.
//   - Next state: RUN if outstanding after this cycle's update is 0, else DRAIN.
//   - First new request is at cycle t+1 when no reads are in flight.
//  Responses in RUN: push {resp_pc,i_mem_data}; resp_pc+=4; outstanding-1.
//   Same-cycle accept and response leave outstanding unchanged.
//   i_mem_valid with outstanding==0 is a protocol error and is ignored (no push, no underflow).
//  Output is combinational from FIFO head: inst_valid = !fifo_empty & !redirect.
//   Pop when inst_valid & !stall. Push and pop in the same cycle are both legal when full.
//   The credit rule guarantees a response never finds the FIFO full.
//  Widths: outstanding and fifo_count are $clog2(MAX_OUTSTANDING+1) bits.
//   PC arithmetic is modulo 2^ADDRESS_BITS (wraps silently).
//  i_mem_read_address = pc, stable while i_mem_read & !i_mem_ready.
//  start is ignored outside IDLE.
// TESTING
//  1 reset, start with program_address=0x100, mem ready, 1-cycle latency -> requests 0x100,
//    0x104 ...; inst_valid from cycle 3, inst_PC 0x100,0x104 in order, instruction = mem data.
//  2 stall held 4 cycles mid-stream -> requests stop at MAX_OUTSTANDING credits;
//    instruction/inst_PC held; no word lost or duplicated after release.
//  3 redirect to 0x200 with 2 reads in flight -> DRAIN, 2 responses dropped, inst_valid=0;
//    next request is 0x200; first delivered inst_PC=0x200.
//  4 redirect with 0 outstanding at cycle t -> i_mem_read=1, address 0x200 at t+1;
//    instruction=NOP during t.
//  5 i_mem_ready low 3 cycles -> address held constant; outstanding unchanged;
//    no spurious inst_valid.
//  6 reset asserted mid-RUN with reads outstanding -> next cycle all outputs at reset values;
//    late i_mem_valid ignored; start required to resume.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues credit-limited sequential reads, buffers returned words
// with their PCs, presents one instruction per cycle to decode and flushes on redirect.
module fetch_sequencer #(
  parameter int unsigned                DATA_WIDTH      = 32,
  parameter int unsigned                ADDRESS_BITS    = 32,
  parameter logic [ADDRESS_BITS-1:0]    RESET_PC        = '0,
  parameter logic [DATA_WIDTH-1:0]      NOP             = 'h00000013,
  parameter int unsigned                MAX_OUTSTANDING = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  input  logic                    stall,
  output logic                    i_mem_read,
  output logic [ADDRESS_BITS-1:0] i_mem_read_address,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW:0]         MaxCredit = (CntW + 1)'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0]       LastPtr   = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [ADDRESS_BITS-1:0] PcStep  = ADDRESS_BITS'(4);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [ADDRESS_BITS-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]         outst_q, outst_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [MAX_OUTSTANDING];
  logic [ADDRESS_BITS-1:0] fifo_pc_q   [MAX_OUTSTANDING];

  logic [CntW:0] credit;
  logic          resp, accept, push, pop, flush;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    credit             = {1'b0, outst_q} + {1'b0, cnt_q};
    // A response with nothing in flight is a protocol error and is discarded.
    resp               = i_mem_valid && (outst_q != '0);
    flush              = redirect && (state_q != StIdle);
    i_mem_read         = (state_q == StRun) && !redirect && (credit < MaxCredit);
    i_mem_read_address = pc_q;
    accept             = i_mem_read && i_mem_ready;
    push               = resp && (state_q == StRun) && !redirect;
    inst_valid         = (cnt_q != '0) && !redirect;
    pop                = inst_valid && !stall;
    instruction        = inst_valid ? fifo_data_q[rd_ptr_q] : NOP;
    inst_PC            = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    unique case ({accept, resp})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d      = program_address;
          resp_pc_d = program_address;
          state_d   = StRun;
        end
      end
      StRun, StDrain: begin
        if (redirect) begin
          pc_d      = redirect_pc;
          resp_pc_d = redirect_pc;
          state_d   = (outst_d == '0) ? StRun : StDrain;
        end else if (state_q == StRun) begin
          if (accept) pc_d = pc_q + PcStep;
          if (push)   resp_pc_d = resp_pc_q + PcStep;
        end else if (outst_d == '0) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= i_mem_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-order instruction-memory responder whose
// responses can be held back to build up reads in flight.
module tb_fetch_sequencer;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] program_address = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        i_mem_read;
  logic [31:0] i_mem_read_address;
  logic        i_mem_ready = 1'b1;
  logic        i_mem_valid = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [31:0] instruction;
  logic [31:0] inst_PC;
  logic        inst_valid;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_pc;
  int unsigned delivered;
  logic        mem_hold = 1'b0;
  logic [31:0] mem_q[$];

  fetch_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .program_address    (program_address),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .stall              (stall),
    .i_mem_read         (i_mem_read),
    .i_mem_read_address (i_mem_read_address),
    .i_mem_ready        (i_mem_ready),
    .i_mem_valid        (i_mem_valid),
    .i_mem_data         (i_mem_data),
    .instruction        (instruction),
    .inst_PC            (inst_PC),
    .inst_valid         (inst_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // In-order memory, one-cycle latency unless held.
  always @(posedge clock) begin
    if (i_mem_read === 1'b1 && i_mem_ready) mem_q.push_back(i_mem_read_address);
    if (!mem_hold && mem_q.size() > 0) begin
      i_mem_valid <= 1'b1;
      i_mem_data  <= word_of(mem_q.pop_front());
    end else begin
      i_mem_valid <= 1'b0;
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    step(); step();
    #1;
    n_cmp++; if (i_mem_read !== 1'b0) begin n_err++; $display("FAIL reset_read got=%b want=0", i_mem_read); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    n_cmp++; if (instruction !== Nop) begin n_err++; $display("FAIL reset_instr got=%h want=%h", instruction, Nop); end
    n_cmp++; if (inst_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h want=0", inst_PC); end
  endtask

  task automatic test_start_stream();
    step(); reset = 1'b0; start = 1'b1; program_address = 32'h100; #1;
    step(); start = 1'b0; #1;
    n_cmp++; if (i_mem_read !== 1'b1 || i_mem_read_address !== 32'h100) begin
      n_err++; $display("FAIL t1_req0 got=%b/%h want=1/00000100", i_mem_read, i_mem_read_address); end
    step(); #1;
    n_cmp++; if (i_mem_read !== 1'b1 || i_mem_read_address !== 32'h104 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL t1_req1 got=%b/%h v=%b want=1/00000104 v=0", i_mem_read, i_mem_read_address, inst_valid); end
    step(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== 32'h100 || instruction !== word_of(32'h100)) begin
      n_err++; $display("FAIL t1_first v=%b pc=%h i=%h want 1/00000100/%h", inst_valid, inst_PC, instruction, word_of(32'h100)); end
    step(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_PC !== 32'h104 || i_mem_read_address !== 32'h108) begin
      n_err++; $display("FAIL t1_second v=%b pc=%h a=%h want 1/00000104/00000108", inst_valid, inst_PC, i_mem_read_address); end
    exp_pc = 32'h108; delivered = 0;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t1_stream pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
        if (!stall) begin exp_pc += 4; delivered++; end
      end
    end
    n_cmp++; if (delivered < 3) begin n_err++; $display("FAIL t1_progress got=%0d want>=3", delivered); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      step(); stall = 1'b1; #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t2_hold pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
      end
      if (i == 3) begin
        n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b1) begin
          n_err++; $display("FAIL t2_credit read=%b v=%b want 0/1", i_mem_read, inst_valid); end
      end
    end
    delivered = 0;
    for (int i = 0; i < 10; i++) begin
      step(); stall = 1'b0; #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t2_stream pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
        exp_pc += 4; delivered++;
      end
    end
    n_cmp++; if (delivered < 4) begin n_err++; $display("FAIL t2_progress got=%0d want>=4", delivered); end
  endtask

  task automatic test_redirect_drain();
    for (int i = 0; i < 5; i++) begin
      step(); mem_hold = 1'b1; #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t3_pre pc=%h want %h", inst_PC, exp_pc); end
        exp_pc += 4;
      end
    end
    n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL t3_inflight read=%b v=%b want 0/0", i_mem_read, inst_valid); end
    step(); mem_hold = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; #1;
    n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b0 || instruction !== Nop) begin
      n_err++; $display("FAIL t3_redir read=%b v=%b i=%h want 0/0/%h", i_mem_read, inst_valid, instruction, Nop); end
    for (int i = 0; i < 2; i++) begin
      step(); redirect = 1'b0; #1;
      n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL t3_drain%0d read=%b v=%b want 0/0", i, i_mem_read, inst_valid); end
    end
    step(); #1;
    n_cmp++; if (i_mem_read !== 1'b1 || i_mem_read_address !== 32'h200) begin
      n_err++; $display("FAIL t3_restart got=%b/%h want 1/00000200", i_mem_read, i_mem_read_address); end
    exp_pc = 32'h200; delivered = 0;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t3_stream pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
        exp_pc += 4; delivered++;
      end
    end
    n_cmp++; if (delivered < 3) begin n_err++; $display("FAIL t3_progress got=%0d want>=3", delivered); end
  endtask

  task automatic test_redirect_idle_credit();
    for (int i = 0; i < 4; i++) begin
      step(); stall = 1'b1; #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc) begin n_err++; $display("FAIL t4_hold pc=%h want %h", inst_PC, exp_pc); end
      end
    end
    n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL t4_full read=%b v=%b want 0/1", i_mem_read, inst_valid); end
    step(); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; #1;
    n_cmp++; if (inst_valid !== 1'b0 || instruction !== Nop || inst_PC !== 32'h0 || i_mem_read !== 1'b0) begin
      n_err++; $display("FAIL t4_redir v=%b i=%h pc=%h r=%b want 0/%h/0/0", inst_valid, instruction, inst_PC, i_mem_read, Nop); end
    step(); redirect = 1'b0; #1;
    n_cmp++; if (i_mem_read !== 1'b1 || i_mem_read_address !== 32'h200) begin
      n_err++; $display("FAIL t4_next got=%b/%h want 1/00000200", i_mem_read, i_mem_read_address); end
    exp_pc = 32'h200; delivered = 0;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t4_stream pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
        exp_pc += 4; delivered++;
      end
    end
    n_cmp++; if (delivered < 3) begin n_err++; $display("FAIL t4_progress got=%0d want>=3", delivered); end
  endtask

  task automatic test_not_ready();
    logic [31:0] held;
    bit          found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(); #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc) begin n_err++; $display("FAIL t5_pre pc=%h want %h", inst_PC, exp_pc); end
        exp_pc += 4;
      end
      found = (i_mem_read === 1'b1);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL t5_wait read never seen within 10 cycles"); end
    i_mem_ready = 1'b0;
    held = i_mem_read_address;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      n_cmp++; if (i_mem_read !== 1'b1 || i_mem_read_address !== held) begin
        n_err++; $display("FAIL t5_held%0d got=%b/%h want 1/%h", i, i_mem_read, i_mem_read_address, held); end
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc) begin n_err++; $display("FAIL t5_valid pc=%h want %h", inst_PC, exp_pc); end
        exp_pc += 4;
      end
    end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t5_bubble v=%b want 0", inst_valid); end
    delivered = 0;
    for (int i = 0; i < 8; i++) begin
      step(); i_mem_ready = 1'b1; #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t5_stream pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
        exp_pc += 4; delivered++;
      end
    end
    n_cmp++; if (delivered < 3) begin n_err++; $display("FAIL t5_progress got=%0d want>=3", delivered); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 5; i++) begin
      step(); mem_hold = 1'b1; #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc) begin n_err++; $display("FAIL t6_pre pc=%h want %h", inst_PC, exp_pc); end
        exp_pc += 4;
      end
    end
    step(); mem_hold = 1'b0; reset = 1'b1; #1;
    step(); reset = 1'b0; #1;
    n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b0 || instruction !== Nop || inst_PC !== 32'h0) begin
      n_err++; $display("FAIL t6_reset r=%b v=%b i=%h pc=%h want 0/0/%h/0", i_mem_read, inst_valid, instruction, inst_PC, Nop); end
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      n_cmp++; if (i_mem_read !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL t6_late%0d r=%b v=%b want 0/0", i, i_mem_read, inst_valid); end
    end
    step(); start = 1'b1; program_address = 32'h400; #1;
    step(); start = 1'b0; #1;
    n_cmp++; if (i_mem_read !== 1'b1 || i_mem_read_address !== 32'h400) begin
      n_err++; $display("FAIL t6_resume got=%b/%h want 1/00000400", i_mem_read, i_mem_read_address); end
    exp_pc = 32'h400; delivered = 0;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (inst_valid) begin
        n_cmp++; if (inst_PC !== exp_pc || instruction !== word_of(exp_pc)) begin
          n_err++; $display("FAIL t6_stream pc=%h i=%h want %h/%h", inst_PC, instruction, exp_pc, word_of(exp_pc)); end
        exp_pc += 4; delivered++;
      end
    end
    n_cmp++; if (delivered < 3) begin n_err++; $display("FAIL t6_progress got=%0d want>=3", delivered); end
  endtask

  initial begin
    test_reset();
    test_start_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_idle_credit();
    test_not_ready();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
